// File: rtl/copyn_stage.sv
// Packet replicator: buffers packets in a small FIFO and emits CCNT+1 copies of each,
// with copy k carrying destination base+k (wrapping) and a cleared copy-count field.
module copyn_stage #(
   parameter int PKT_W    = 40,
   parameter int DEST_W   = 10,
   parameter int DEST_LSB = 20,
   parameter int CCNT_W   = 3,
   parameter int CCNT_LSB = 30,
   parameter int DEPTH    = 4
) (
   input  logic             CLK,
   input  logic             MR,
   input  logic             Send_in,
   output logic             Ack_out,
   input  logic [PKT_W-1:0] PACKET_IN,
   output logic             Send_out,
   input  logic             Ack_in,
   output logic [PKT_W-1:0] PACKET_OUT,
   output logic             Busy
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {IDLE, EMIT} state_t;

   state_t              state, state_nxt;
   logic [CCNT_W-1:0]   idx, idx_nxt;
   logic [CCNT_W-1:0]   ncopy;
   logic [PKT_W-1:0]    base;

   logic [PKT_W-1:0]    mem [DEPTH];
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic [AW:0]         count;
   logic                full, empty, push, pop;
   logic [PKT_W-1:0]    head;

   logic                slot_free, load, ld_base;
   logic [PKT_W-1:0]    load_pkt;

   function automatic logic [PKT_W-1:0] make_copy(input logic [PKT_W-1:0] pkt,
                                                  input logic [CCNT_W-1:0] k);
      logic [PKT_W-1:0]  res;
      logic [DEST_W-1:0] d;
      res = pkt;
      d   = pkt[DEST_LSB +: DEST_W] + DEST_W'(k);
      res[DEST_LSB +: DEST_W] = d;
      res[CCNT_LSB +: CCNT_W] = '0;
      return res;
   endfunction

   // Full is taken from registered occupancy only, so a same-cycle pop never frees a slot.
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign Ack_out = ~full;
   assign push    = Send_in & ~full;
   assign head    = mem[rd_ptr];

   always_ff @(posedge CLK or negedge MR) begin
      if (!MR) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= PACKET_IN;
   end

   assign slot_free = ~Send_out | Ack_in;

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      pop       = 1'b0;
      load      = 1'b0;
      ld_base   = 1'b0;
      load_pkt  = '0;
      case (state)
         IDLE: begin
            if (!empty && slot_free) begin
               pop      = 1'b1;
               ld_base  = 1'b1;
               load     = 1'b1;
               load_pkt = make_copy(head, '0);
               if (head[CCNT_LSB +: CCNT_W] != '0) begin
                  state_nxt = EMIT;
                  idx_nxt   = CCNT_W'(1);
               end
            end
         end
         EMIT: begin
            if (slot_free) begin
               load     = 1'b1;
               load_pkt = make_copy(base, idx);
               if (idx == ncopy) begin
                  state_nxt = IDLE;
                  idx_nxt   = '0;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge MR) begin
      if (!MR) begin
         state      <= IDLE;
         idx        <= '0;
         ncopy      <= '0;
         Send_out   <= 1'b0;
         PACKET_OUT <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         if (ld_base) ncopy <= head[CCNT_LSB +: CCNT_W];
         if (load) begin
            Send_out   <= 1'b1;
            PACKET_OUT <= load_pkt;
         end else if (slot_free) begin
            Send_out   <= 1'b0;
         end
      end
   end

   // Base packet is pure data; it is only read while in EMIT, after being loaded.
   always_ff @(posedge CLK) begin
      if (ld_base) base <= head;
   end

   assign Busy = ~empty | (state == EMIT) | Send_out;

endmodule
